instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the decode stage, upstream of the boot/program
//  ROM (single-port block RAM, 1-cycle synchronous read, if_ram_1way style port).
//  Holds the PC, issues one word read per cycle and tracks the in-flight read.
//  Buffers returned words in a 2-entry FIFO so decode back-pressure never loses
//  or duplicates an instruction. Handles jump/branch redirects by flushing.
// PARAMETERS
//  ADDR_WIDTH  12         ROM word-address width (ROM depth = 2**ADDR_WIDTH words)
//  DATA_WIDTH  32         instruction width
//  BOOT_ADDR   32'h0      byte address of the first fetch after reset
// PORTS
//  clk            in   1           clock, all logic on rising edge
//  rst            in   1           synchronous, active-high reset
//  rom_addr       out  ADDR_WIDTH  ROM word address (= fetch byte addr [ADDR_WIDTH+1:2])
//  rom_rdata      in   DATA_WIDTH  ROM read data, valid 1 cycle after rom_addr
//  instr_o        out  DATA_WIDTH  instruction at FIFO head
//  instr_addr_o   out  32          byte address of instr_o
//  instr_valid_o  out  1           FIFO head valid
//  instr_ready_i  in   1           decode accepts instr_o this cycle
//  jmp_i          in   1           redirect request (1-cycle pulse)
//  jmp_addr_i     in   32          redirect byte address; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst). All state cleared in
//    the cycle rst is sampled high.
//  - Reset values: fetch_pc=BOOT_ADDR, FIFO count=0, inflight=0,
//    instr_valid_o=0, instr_o=0, instr_addr_o=0. rom_addr is combinational and
//    shows BOOT_ADDR word during reset; no read counts as issued while rst=1.
//  - pop = instr_valid_o & instr_ready_i. Payload stable while valid & !ready.
//  - issue (cycle N, no jump) when count + inflight - pop < 2; rom_addr =
//    fetch_pc word; fetch_pc += 4 at the edge; inflight set for N+1.
//    No issue: rom_addr still driven, inflight=0, fetch_pc unchanged.
//  - Response: in cycle N+1, if inflight, rom_rdata plus its byte address are
//    pushed into the FIFO at the edge -> visible on instr_o in cycle N+2
//    (fetch-to-decode latency 2 cycles). Count never exceeds 2.
//  - Throughput: with instr_ready_i held 1, one instruction per cycle steady state.
//  - Simultaneous push and pop: count unchanged, order preserved.
//  - Jump (jmp_i=1 in cycle N), highest priority: FIFO flushed, inflight
//    response of cycle N discarded; rom_addr = jmp_addr_i word combinationally
//    in cycle N (always issued); fetch_pc = jmp_addr_i+4. A pop in cycle N
//    still counts as accepted. Target instr valid in cycle N+2.
//  - Address wrap: fetch_pc is 32 bits; rom_addr = fetch_pc[ADDR_WIDTH+1:2],
//    so fetches beyond ROM end alias modulo ROM size; instr_addr_o keeps full
//    32-bit PC. fetch_pc 0xFFFFFFFC wraps to 0.
//  - Reset mid-operation: inflight read and FIFO contents dropped; restart at
//    BOOT_ADDR with the same 2-cycle latency.
// TESTING (ROM preloaded with mem[i] = 0xA0000000 | i)
//  1 Reset released, ready=1 -> valid first in cycle 2 after rst low;
//    instr_addr_o 0,4,8.. consecutive cycles, instr_o 0xA0000000,0xA0000001..
//  2 ready=0 for 5 cycles after 3 accepts -> valid held, instr_o=0xA0000003 stable;
//    on ready=1 stream resumes 3,4,5 with no gap, loss or duplicate.
//  3 jmp_i pulse, jmp_addr_i=0x100, ready=1 -> rom_addr=0x40 same cycle; old
//    words dropped; 2 cycles later instr_addr_o=0x100, instr_o=0xA0000040.
//  4 FIFO full (ready=0, count=2) + jmp_i to 0x20 -> valid low next cycle,
//    then instr_addr_o=0x20 with ready still 0 held stable.
//  5 ADDR_WIDTH=4, run past 0x3C -> instr_addr_o=0x40, rom_addr=0,
//    instr_o=0xA0000000.
//  6 rst pulsed with FIFO full and read in flight -> valid=0 next cycle,
//    restart at BOOT_ADDR after 2 cycles, no stale word emitted.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one ROM word read per cycle and
// buffers returned words in a 2-entry FIFO toward decode; jumps flush and redirect.
module instr_fetch_unit #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] BOOT_ADDR  = 32'h0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_rdata,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [31:0]           instr_addr_o,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   input  logic                  jmp_i,
   input  logic [31:0]           jmp_addr_i
);

   logic [31:0]           fetch_pc_q, fetch_pc_d;
   logic                  inflight_q, inflight_d;
   logic [31:0]           inflight_addr_q, inflight_addr_d;
   logic [DATA_WIDTH-1:0] fifo_data_q [2];
   logic [31:0]           fifo_addr_q [2];
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;

   logic [31:0] jmp_target;
   logic        pop;
   logic        push;
   logic        has_space;
   logic [1:0]  occupancy;
   logic        wr_idx;

   assign jmp_target    = jmp_addr_i & ~32'h3;
   assign instr_valid_o = (count_q != 2'd0);
   assign instr_o       = fifo_data_q[rd_ptr_q];
   assign instr_addr_o  = fifo_addr_q[rd_ptr_q];
   assign pop           = instr_valid_o & instr_ready_i;
   assign push          = inflight_q & ~jmp_i;

   // Entries already held or promised, after this cycle's pop; never exceeds 2.
   assign occupancy = count_q + 2'(inflight_q) - 2'(pop);
   assign has_space = (occupancy < 2'd2);
   assign wr_idx    = rd_ptr_q ^ count_q[0];

   always_comb begin
      if (rst) begin
         rom_addr = BOOT_ADDR[ADDR_WIDTH+1:2];
      end else if (jmp_i) begin
         rom_addr = jmp_target[ADDR_WIDTH+1:2];
      end else begin
         rom_addr = fetch_pc_q[ADDR_WIDTH+1:2];
      end
   end

   always_comb begin
      fetch_pc_d      = fetch_pc_q;
      inflight_d      = 1'b0;
      inflight_addr_d = inflight_addr_q;
      count_d         = count_q;
      rd_ptr_d        = rd_ptr_q;
      if (jmp_i) begin
         // Redirect always issues; the response arriving this cycle is stale.
         fetch_pc_d      = jmp_target + 32'd4;
         inflight_d      = 1'b1;
         inflight_addr_d = jmp_target;
         count_d         = 2'd0;
         rd_ptr_d        = 1'b0;
      end else begin
         if (has_space) begin
            fetch_pc_d      = fetch_pc_q + 32'd4;
            inflight_d      = 1'b1;
            inflight_addr_d = fetch_pc_q;
         end
         count_d  = count_q + 2'(push) - 2'(pop);
         rd_ptr_d = rd_ptr_q ^ pop;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q      <= BOOT_ADDR;
         inflight_q      <= 1'b0;
         inflight_addr_q <= 32'h0;
         count_q         <= 2'd0;
         rd_ptr_q        <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_addr_q[i] <= 32'h0;
         end
      end else begin
         fetch_pc_q      <= fetch_pc_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
         count_q         <= count_d;
         rd_ptr_q        <= rd_ptr_d;
         if (push) begin
            fifo_data_q[wr_idx] <= rom_rdata;
            fifo_addr_q[wr_idx] <= inflight_addr_q;
         end
      end
   end

endmodule
